// File: rtl/counterup16_timer_ctrl_1clk_posedge_sync_reset.sv
// Command-driven controller for a 16-bit up counter used as a programmable timer:
// period compare, prescaler, one-shot/periodic modes, terminal tick and sticky error.
module counterup16_timer_ctrl_1clk_posedge_sync_reset #(
  parameter int WIDTH  = 16,
  parameter int PWIDTH = 8
) (
  input  logic              clock0,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic              periodic,
  input  logic [PWIDTH-1:0] prescale,
  output logic [WIDTH-1:0]  count,
  output logic [1:0]        state,
  output logic              busy,
  output logic              tick,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [WIDTH-1:0]  CNT_ONE = WIDTH'(1);
  localparam logic [PWIDTH-1:0] PRE_ONE = PWIDTH'(1);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [PWIDTH-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]  period_q, period_d;
  logic              periodic_q, periodic_d;
  logic [PWIDTH-1:0] prescale_q, prescale_d;
  logic              tick_q, tick_d;
  logic              err_q, err_d;
  logic              ready_q;

  logic accept;
  logic step;
  logic terminal;

  // State register
  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      presc_q    <= '0;
      period_q   <= '1;
      periodic_q <= 1'b0;
      prescale_q <= '0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      prescale_q <= prescale_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
      ready_q    <= 1'b1;
    end
  end

  // Next-state logic: counting action first, then the accepted command layered on top
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    prescale_d = prescale_q;
    err_d      = err_q;

    accept   = cmd_valid && ready_q;
    step     = (state_q == S_RUN) && (presc_q == prescale_q);
    terminal = step && (count_q == period_q);
    tick_d   = terminal;

    if (state_q == S_RUN) begin
      presc_d = step ? '0 : presc_q + PRE_ONE;
    end

    if (step) begin
      if (terminal) begin
        if (periodic_q) begin
          count_d = '0;
        end else begin
          state_d = S_DONE;
        end
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end

    // Commands are judged against the pre-edge state, so a terminal-cycle START/LOAD still errs
    if (accept) begin
      case (cmd_op)
        OP_START: begin
          case (state_q)
            S_IDLE, S_DONE: begin
              state_d    = S_RUN;
              count_d    = '0;
              presc_d    = '0;
              periodic_d = periodic;
              prescale_d = prescale;
            end
            S_PAUSE: state_d = S_RUN;
            default: err_d = 1'b1;
          endcase
        end
        OP_STOP: begin
          if ((state_q == S_RUN) && !(terminal && !periodic_q)) begin
            state_d = S_PAUSE;
          end
        end
        OP_LOAD: begin
          if (state_q == S_RUN) begin
            err_d = 1'b1;
          end else begin
            period_d = cmd_data;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
          presc_d = '0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    cmd_ready = ready_q;
    count     = count_q;
    state     = state_q;
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    tick      = tick_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_counterup16_timer_ctrl_1clk_posedge_sync_reset.sv
// Scoreboard bench: the driver queues hand-computed post-edge outputs for every cycle,
// a monitor pops and compares them one time unit after each rising edge.
`timescale 1ns/1ps
module tb_counterup16_timer_ctrl_1clk_posedge_sync_reset;

  localparam logic [1:0] ST_I = 2'b00, ST_R = 2'b01, ST_P = 2'b10, ST_D = 2'b11;
  localparam logic [1:0] OP_START = 2'b00, OP_STOP = 2'b01, OP_LOAD = 2'b10, OP_CLEAR = 2'b11;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        periodic;
  logic [7:0]  prescale;
  logic [15:0] count;
  logic [1:0]  state;
  logic        busy;
  logic        tick;
  logic        done;
  logic        err;

  counterup16_timer_ctrl_1clk_posedge_sync_reset #(.WIDTH(16), .PWIDTH(8)) dut (
    .clock0    (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .periodic  (periodic),
    .prescale  (prescale),
    .count     (count),
    .state     (state),
    .busy      (busy),
    .tick      (tick),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ready, err, tick, done, busy, state[1:0], count[15:0]}
  typedef struct {
    logic [22:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Monitor
  always @(posedge clk) begin
    exp_t        me;
    logic [22:0] act;
    #1;
    if (exp_q.size() != 0) begin
      me  = exp_q.pop_front();
      act = {cmd_ready, err, tick, done, busy, state, count};
      checks++;
      if (act !== me.v) begin
        fails++;
        $display("FAIL %s @%0t: got rdy=%b err=%b tick=%b done=%b busy=%b st=%0d cnt=%0d, expected rdy=%b err=%b tick=%b done=%b busy=%b st=%0d cnt=%0d",
                 me.name, $time, act[22], act[21], act[20], act[19], act[18], act[17:16], act[15:0],
                 me.v[22], me.v[21], me.v[20], me.v[19], me.v[18], me.v[17:16], me.v[15:0]);
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [1:0] op, input logic [15:0] d,
                     input logic per, input logic [7:0] pre,
                     input logic [15:0] ec, input logic [1:0] es, input logic et,
                     input logic ee, input logic er, input string nm);
    exp_t e;
    @(negedge clk);
    reset     = r;
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    periodic  = per;
    prescale  = pre;
    e.v    = {er, ee, et, (es == ST_D), (es == ST_R), es, ec};
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [15:0] ec, input logic [1:0] es, input logic et,
                      input logic ee, input string nm);
    cyc(1'b0, 1'b0, OP_START, 16'h0, 1'b0, 8'h0, ec, es, et, ee, 1'b1, nm);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [15:0] d, input logic per, input logic [7:0] pre,
                     input logic [15:0] ec, input logic [1:0] es, input logic et,
                     input logic ee, input string nm);
    cyc(1'b0, 1'b1, op, d, per, pre, ec, es, et, ee, 1'b1, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 16'h0;
    periodic = 1'b0; prescale = 8'h0;

    // Reset state, then release
    cyc(1'b1, 1'b0, OP_START, 16'h0, 1'b0, 8'h0, 16'd0, ST_I, 1'b0, 1'b0, 1'b0, "reset");
    cyc(1'b1, 1'b0, OP_START, 16'h0, 1'b0, 8'h0, 16'd0, ST_I, 1'b0, 1'b0, 1'b0, "reset2");
    idle(16'd0, ST_I, 1'b0, 1'b0, "release");

    // Periodic, period 3, prescale 0
    cmd(OP_LOAD,  16'd3, 1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "load3");
    cmd(OP_START, 16'd0, 1'b1, 8'd0, 16'd0, ST_R, 1'b0, 1'b0, "start_per3");
    for (int i = 1; i <= 8; i++)
      idle(16'(i % 4), ST_R, (i % 4) == 0, 1'b0, "per3_run");
    cmd(OP_CLEAR, 16'd0, 1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "clear1");

    // One-shot, period 5, prescale 2
    cmd(OP_LOAD,  16'd5, 1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "load5");
    cmd(OP_START, 16'd0, 1'b0, 8'd2, 16'd0, ST_R, 1'b0, 1'b0, "start_os5");
    for (int i = 1; i <= 18; i++)
      idle((i == 18) ? 16'd5 : 16'(i / 3), (i == 18) ? ST_D : ST_R, i == 18, 1'b0, "os5_run");
    for (int i = 0; i < 3; i++)
      idle(16'd5, ST_D, 1'b0, 1'b0, "os5_hold");

    // Pause and resume, periodic period 10
    cmd(OP_CLEAR, 16'd0,  1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "clear2");
    cmd(OP_LOAD,  16'd10, 1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "load10");
    cmd(OP_START, 16'd0,  1'b1, 8'd0, 16'd0, ST_R, 1'b0, 1'b0, "start_per10");
    for (int i = 1; i <= 3; i++)
      idle(16'(i), ST_R, 1'b0, 1'b0, "per10_run");
    cmd(OP_STOP, 16'd0, 1'b0, 8'd0, 16'd4, ST_P, 1'b0, 1'b0, "stop_at4");
    for (int i = 0; i < 20; i++)
      idle(16'd4, ST_P, 1'b0, 1'b0, "paused");
    cmd(OP_START, 16'd0, 1'b0, 8'd0, 16'd4, ST_R, 1'b0, 1'b0, "resume");
    idle(16'd5, ST_R, 1'b0, 1'b0, "resume_5");
    idle(16'd6, ST_R, 1'b0, 1'b0, "resume_6");

    // Illegal commands in RUN
    cmd(OP_LOAD,  16'd7, 1'b0, 8'd0, 16'd7, ST_R, 1'b0, 1'b1, "load_in_run");
    cmd(OP_START, 16'd0, 1'b0, 8'd0, 16'd8, ST_R, 1'b0, 1'b1, "start_in_run");
    idle(16'd9,  ST_R, 1'b0, 1'b1, "err_sticky9");
    idle(16'd10, ST_R, 1'b0, 1'b1, "err_sticky10");
    idle(16'd0,  ST_R, 1'b1, 1'b1, "period_kept10");
    idle(16'd1,  ST_R, 1'b0, 1'b1, "err_sticky1");
    cmd(OP_CLEAR, 16'd0, 1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "clear_err");

    // Periodic STOP exactly on terminal step
    cmd(OP_LOAD,  16'd2, 1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "load2");
    cmd(OP_START, 16'd0, 1'b1, 8'd0, 16'd0, ST_R, 1'b0, 1'b0, "start_per2");
    idle(16'd1, ST_R, 1'b0, 1'b0, "per2_1");
    idle(16'd2, ST_R, 1'b0, 1'b0, "per2_2");
    cmd(OP_STOP, 16'd0, 1'b0, 8'd0, 16'd0, ST_P, 1'b1, 1'b0, "stop_on_term");
    idle(16'd0, ST_P, 1'b0, 1'b0, "paused_after_term");
    cmd(OP_CLEAR, 16'd0, 1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "clear3");

    // One-shot CLEAR on terminal step
    cmd(OP_START, 16'd0, 1'b0, 8'd0, 16'd0, ST_R, 1'b0, 1'b0, "start_os2");
    idle(16'd1, ST_R, 1'b0, 1'b0, "os2_1");
    idle(16'd2, ST_R, 1'b0, 1'b0, "os2_2");
    cmd(OP_CLEAR, 16'd0, 1'b0, 8'd0, 16'd0, ST_I, 1'b1, 1'b0, "clear_on_term");
    idle(16'd0, ST_I, 1'b0, 1'b0, "idle_after_clear");

    // One-shot STOP on terminal step is ignored; START from DONE restarts
    cmd(OP_START, 16'd0, 1'b0, 8'd0, 16'd0, ST_R, 1'b0, 1'b0, "start_os2b");
    idle(16'd1, ST_R, 1'b0, 1'b0, "os2b_1");
    idle(16'd2, ST_R, 1'b0, 1'b0, "os2b_2");
    cmd(OP_STOP, 16'd0, 1'b0, 8'd0, 16'd2, ST_D, 1'b1, 1'b0, "stop_on_os_term");
    idle(16'd2, ST_D, 1'b0, 1'b0, "done_hold");
    cmd(OP_START, 16'd0, 1'b1, 8'd0, 16'd0, ST_R, 1'b0, 1'b0, "start_from_done");

    // Period 0 with prescale 1: every step is terminal
    cmd(OP_CLEAR, 16'd0, 1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "clear4");
    cmd(OP_LOAD,  16'd0, 1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "load0");
    cmd(OP_START, 16'd0, 1'b1, 8'd1, 16'd0, ST_R, 1'b0, 1'b0, "start_p0");
    for (int i = 1; i <= 4; i++)
      idle(16'd0, ST_R, (i % 2) == 0, 1'b0, "period0_run");

    // Reset mid-run at count 9
    cmd(OP_CLEAR, 16'd0,  1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "clear5");
    cmd(OP_LOAD,  16'd20, 1'b0, 8'd0, 16'd0, ST_I, 1'b0, 1'b0, "load20");
    cmd(OP_START, 16'd0,  1'b1, 8'd0, 16'd0, ST_R, 1'b0, 1'b0, "start_per20");
    for (int i = 1; i <= 9; i++)
      idle(16'(i), ST_R, 1'b0, 1'b0, "per20_run");
    cyc(1'b1, 1'b1, OP_START, 16'h0, 1'b1, 8'h0, 16'd0, ST_I, 1'b0, 1'b0, 1'b0, "reset_mid");
    cyc(1'b1, 1'b0, OP_START, 16'h0, 1'b0, 8'h0, 16'd0, ST_I, 1'b0, 1'b0, 1'b0, "reset_hold");
    idle(16'd0, ST_I, 1'b0, 1'b0, "release2");
    cmd(OP_START, 16'd0, 1'b1, 8'd0, 16'd0, ST_R, 1'b0, 1'b0, "start_after_reset");
    for (int i = 1; i <= 25; i++)
      idle(16'(i), ST_R, 1'b0, 1'b0, "period_ffff");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
